// File: rtl/jof32_ex_pkg.sv
// Shared encodings for the JOF32 Execute-stage multiply/divide unit:
// function codes, the signed-select bit, FSM states and the latched request.
package jof32_ex_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_MULH = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_REM  = 2'b11;

    localparam int OP_SIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } md_state_e;

    // fn[1] distinguishes divide from multiply; dz remembers op_b==0 at accept
    typedef struct packed {
        logic [1:0] fn;
        logic       dz;
    } md_req_t;

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational iteration of the muldiv datapath: shift-add multiply
// step or restoring trial-subtract divide step, chosen by is_div.
module ex_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] addend;

    always_comb begin
        addend  = lo[0] ? b : '0;
        sum     = {1'b0, hi} + {1'b0, addend};
        shifted = {hi, lo[WIDTH-1]};
        // The remainder stays below the divisor, so WIDTH+1 bits hold the borrow
        trial   = shifted - {1'b0, b};
        hi_nxt  = sum[WIDTH:1];
        lo_nxt  = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (trial[WIDTH]) begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_nxt = trial[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit beside the JOF32 ALU, one step per cycle.
// Signed operation is built only when JOF32_MULDIV_SIGNED_EN is defined.
module ex_muldiv_unit
    import jof32_ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    md_state_e        state, state_nxt;
    md_req_t          req;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_mag;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot, rem, res_fix;
    logic             accept;

    assign accept = (state == ST_IDLE) && start && !kill;
    assign busy   = (state != ST_IDLE);

`ifdef JOF32_MULDIV_SIGNED_EN
    logic sgn, a_neg, b_neg;
    logic neg_q, neg_r;

    assign sgn   = op[OP_SIGNED_BIT];
    assign a_neg = sgn & op_a[WIDTH-1];
    assign b_neg = sgn & op_b[WIDTH-1];
    assign a_abs = a_neg ? -op_a : op_a;
    assign b_abs = b_neg ? -op_b : op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    logic unused_sign;
    assign unused_sign = op[OP_SIGNED_BIT];
    assign a_abs       = op_a;
    assign b_abs       = op_b;
`endif

    ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (req.fn[1]),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .b      (b_mag),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && !kill) state_nxt = ST_CALC;
            ST_CALC: begin
                if (kill)                 state_nxt = ST_IDLE;
                else if (cnt == CW'(1))   state_nxt = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sign fix-up and result select, applied on the way out of FIN
    always_comb begin
        prod = {acc_hi, acc_lo};
        quot = acc_lo;
        rem  = acc_hi;
`ifdef JOF32_MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -prod;
            quot = -quot;
        end
        if (neg_r) rem = -rem;
`endif
        case (req.fn)
            MD_MUL:  res_fix = prod[WIDTH-1:0];
            MD_MULH: res_fix = prod[2*WIDTH-1:WIDTH];
            MD_DIV:  res_fix = req.dz ? '1 : quot;
            MD_REM:  res_fix = req.dz ? a_q : rem;
            default: res_fix = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req      <= '0;
            cnt      <= '0;
            a_q      <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result   <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                req    <= '{fn: op[1:0], dz: (op_b == '0)};
                cnt    <= CW'(WIDTH);
                a_q    <= op_a;
                b_mag  <= b_abs;
                acc_hi <= '0;
                acc_lo <= a_abs;
            end else if (state == ST_CALC && !kill) begin
                acc_hi <= hi_nxt;
                acc_lo <= lo_nxt;
                cnt    <= cnt - CW'(1);
            end else if (state == ST_FIN && !kill) begin
                result   <= res_fix;
                div_zero <= req.fn[1] & req.dz;
                done     <= 1'b1;
            end
        end
    end

endmodule
